// File: rtl/ldpc_cn_minsum_if.sv
// Lane-packed stream used on both sides of the min-sum check node:
// eight magnitudes plus eight sign bits per beat, with a row-end marker.
interface ldpc_cn_minsum_if #(
  parameter int WIDTH = 16
);
  // A beat transfers on a rising clock edge where valid && ready. The master
  // holds mag/sign/last stable while valid && !ready; ready may change freely.
  logic [8*WIDTH-1:0] mag;
  logic [7:0]         sign;
  logic               valid;
  logic               last;
  logic               ready;

  modport master (output mag, output sign, output valid, output last, input ready);
  modport slave  (input mag, input sign, input valid, input last, output ready);
endinterface

// File: rtl/ldpc_cn_minsum.sv
// Offset-min-sum LDPC check node: accumulates one row of up to MAX_BEATS
// eight-lane beats, then replays the row with extrinsic magnitudes and signs.
module ldpc_cn_minsum #(
  parameter int WIDTH     = 16,
  parameter int MAX_BEATS = 8,
  parameter int OFFSET    = 0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  ldpc_cn_minsum_if.slave         in_if,
  ldpc_cn_minsum_if.master        out_if,
  output logic [1:0]              dbg_state
);

  localparam int IDX_W  = $clog2(MAX_BEATS * 8);
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);
  localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [WIDTH-1:0] OFF = WIDTH'(OFFSET);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [WIDTH-1:0]   min1;
  logic [WIDTH-1:0]   min2;
  logic [IDX_W-1:0]   min1_idx;
  logic               sign_prod;
  logic [7:0]         sign_mem [MAX_BEATS];

  logic               accept;
  logic               xfer;
  logic               row_end;
  logic               out_end;
  logic [BEAT_W-1:0]  in_beat;
  logic [BEAT_W-1:0]  out_beat;

  logic [WIDTH-1:0]   c_min1;
  logic [WIDTH-1:0]   c_min2;
  logic [IDX_W-1:0]   c_idx;
  logic               c_sign_prod;
  logic [WIDTH-1:0]   lane_mag;
  logic [WIDTH-1:0]   lane_sel;

  assign in_if.ready  = !i_reset && (state != EMIT);
  assign out_if.valid = !i_reset && (state == EMIT);
  assign accept       = in_if.valid && in_if.ready;
  assign xfer         = out_if.valid && out_if.ready;
  assign row_end      = in_if.last || (int'(in_cnt) == MAX_BEATS - 1);
  assign out_end      = (out_cnt == in_cnt - CNT_W'(1));
  assign in_beat      = BEAT_W'(in_cnt);
  assign out_beat     = BEAT_W'(out_cnt);
  assign dbg_state    = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = row_end ? EMIT : ACCUM;
      ACCUM:   if (accept && row_end) state_nxt = EMIT;
      EMIT:    if (xfer && out_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Trackers restart from all-ones on a row's first beat. Lanes are scanned in
  // index order with strict '<' so min1 keeps the lowest index on ties, while
  // an equal value elsewhere still lands in min2.
  always_comb begin
    c_min1      = (state == IDLE) ? '1 : min1;
    c_min2      = (state == IDLE) ? '1 : min2;
    c_idx       = (state == IDLE) ? '0 : min1_idx;
    c_sign_prod = (state == IDLE) ? 1'b0 : sign_prod;
    lane_mag    = '0;
    for (int k = 0; k < 8; k++) begin
      lane_mag = in_if.mag[k*WIDTH +: WIDTH];
      if (lane_mag < c_min1) begin
        c_min2 = c_min1;
        c_min1 = lane_mag;
        c_idx  = IDX_W'(int'(in_cnt) * 8 + k);
      end else if (lane_mag < c_min2) begin
        c_min2 = lane_mag;
      end
    end
    c_sign_prod = c_sign_prod ^ (^in_if.sign);
  end

  always_comb begin
    out_if.mag  = '0;
    out_if.sign = '0;
    out_if.last = 1'b0;
    lane_sel    = '0;
    if (out_if.valid) begin
      for (int k = 0; k < 8; k++) begin
        lane_sel = (int'(out_cnt) * 8 + k == int'(min1_idx)) ? min2 : min1;
        out_if.mag[k*WIDTH +: WIDTH] = (lane_sel > OFF) ? (lane_sel - OFF) : '0;
      end
      out_if.sign = sign_mem[out_beat] ^ {8{sign_prod}};
      out_if.last = out_end;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      min1      <= '0;
      min2      <= '0;
      min1_idx  <= '0;
      sign_prod <= 1'b0;
      for (int b = 0; b < MAX_BEATS; b++) sign_mem[b] <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sign_mem[in_beat] <= in_if.sign;
        min1              <= c_min1;
        min2              <= c_min2;
        min1_idx          <= c_idx;
        sign_prod         <= c_sign_prod;
        in_cnt            <= in_cnt + CNT_W'(1);
      end
      if (xfer) begin
        if (out_end) begin
          out_cnt <= '0;
          in_cnt  <= '0;
        end else begin
          out_cnt <= out_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ldpc_cn_minsum.sv
// Bench for ldpc_cn_minsum: two instances (OFFSET 0 and 3) share one input
// stream; results are checked against hand tables and a row-level model.
module tb_ldpc_cn_minsum;

  localparam int W  = 16;
  localparam int EW = 1 + 16 + 16 * W;

  logic clk;
  logic rst;
  logic [8*W-1:0] mag_d;
  logic [7:0]     sign_d;
  logic           valid_d;
  logic           last_d;
  logic           ready_d;
  logic [1:0]     dbg0;
  logic [1:0]     dbg3;

  ldpc_cn_minsum_if #(.WIDTH(W)) in0 ();
  ldpc_cn_minsum_if #(.WIDTH(W)) out0 ();
  ldpc_cn_minsum_if #(.WIDTH(W)) in3 ();
  ldpc_cn_minsum_if #(.WIDTH(W)) out3 ();

  assign in0.mag = mag_d;  assign in0.sign = sign_d;
  assign in0.valid = valid_d;  assign in0.last = last_d;
  assign in3.mag = mag_d;  assign in3.sign = sign_d;
  assign in3.valid = valid_d;  assign in3.last = last_d;
  assign out0.ready = ready_d;
  assign out3.ready = ready_d;

  ldpc_cn_minsum #(.WIDTH(W), .MAX_BEATS(8), .OFFSET(0)) dut0 (
    .i_clock(clk), .i_reset(rst), .in_if(in0), .out_if(out0), .dbg_state(dbg0));
  ldpc_cn_minsum #(.WIDTH(W), .MAX_BEATS(8), .OFFSET(3)) dut3 (
    .i_clock(clk), .i_reset(rst), .in_if(in3), .out_if(out3), .dbg_state(dbg3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  row_mag [8][8];
  logic [7:0]    row_sign [8];

  typedef struct {
    logic [W-1:0] mag [8];
    logic [7:0]   sign;
    logic [W-1:0] e0 [8];
    logic [W-1:0] e3 [8];
    logic [7:0]   esign;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] cur_out();
    return {out0.last, out0.sign, out3.sign, out0.mag, out3.mag};
  endfunction

  // Row-level reference: min over all edges, first index holding it,
  // minimum over every other edge, then offset with floor at zero.
  task automatic push_model(input int n);
    int mn1, mn2, idx, v, sel, m3;
    bit sp;
    logic [8*W-1:0] v0, v3;
    logic [7:0] sg;
    mn1 = 1 << W;
    mn2 = 1 << W;
    idx = -1;
    sp  = 1'b0;
    for (int j = 0; j < n * 8; j++) begin
      v = int'(row_mag[j/8][j%8]);
      if (v < mn1) mn1 = v;
    end
    for (int j = 0; j < n * 8; j++)
      if (idx < 0 && int'(row_mag[j/8][j%8]) == mn1) idx = j;
    for (int j = 0; j < n * 8; j++)
      if (j != idx && int'(row_mag[j/8][j%8]) < mn2) mn2 = int'(row_mag[j/8][j%8]);
    for (int b = 0; b < n; b++) sp ^= ^row_sign[b];
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 8; k++) begin
        sel = (b * 8 + k == idx) ? mn2 : mn1;
        m3  = (sel - 3 < 0) ? 0 : sel - 3;
        v0[k*W +: W] = W'(sel);
        v3[k*W +: W] = W'(m3);
      end
      sg = row_sign[b] ^ {8{sp}};
      exp_q.push_back({(b == n - 1), sg, sg, v0, v3});
    end
  endtask

  // driver: n beats, i_last on the final one when use_last is set
  task automatic send_row(input int n, input bit use_last);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      valid_d = 1'b1;
      last_d  = use_last && (b == n - 1);
      for (int k = 0; k < 8; k++) mag_d[k*W +: W] = row_mag[b][k];
      sign_d = row_sign[b];
      #1;
      chk("in_ready", in0.ready, 1);
    end
    @(negedge clk);
    valid_d = 1'b0;
    last_d  = 1'b0;
    #1;
    chk("first_valid", out0.valid, 1);
    chk("ready_in_emit", in0.ready, 0);
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1, 2: random
  task automatic collect(input int nb, input int mode);
    int got = 0;
    int cyc = 0;
    int pat = 0;
    logic held = 1'b0;
    logic [EW-1:0] prev = '0;
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    while (got < nb && cyc < 200) begin
      @(negedge clk);
      cyc++;
      case (mode)
        0:       ready_d = 1'b1;
        1:       ready_d = (pat % 4 == 0) || (pat % 4 == 3);
        default: ready_d = 1'($urandom_range(0, 1));
      endcase
      pat++;
      #1;
      act = cur_out();
      if (held) chk("hold_stable", act, prev);
      if (out0.valid) begin
        if (ready_d) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          chk("out_beat", act, exp);
          got++;
        end
        held = !ready_d;
        prev = act;
      end else begin
        held = 1'b0;
      end
    end
    if (got < nb) chk("collect_timeout", got, nb);
  endtask

  task automatic post_check();
    @(negedge clk);
    ready_d = 1'b0;
    #1;
    chk("idle_valid", out0.valid, 0);
    chk("idle_ready", in0.ready, 1);
  endtask

  task automatic rand_row(input int n);
    bit narrow;
    narrow = 1'($urandom_range(0, 1));
    for (int b = 0; b < n; b++) begin
      row_sign[b] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 8; k++)
        row_mag[b][k] = narrow ? W'($urandom_range(0, 6)) : W'($urandom_range(0, 65535));
    end
  endtask

  initial begin
    logic [8*W-1:0] v0, v3;
    int n, mode;
    bit use_last;

    tbl[0].mag = '{5, 3, 9, 7, 3, 8, 6, 4};  tbl[0].sign = 8'h01;
    tbl[0].e0  = '{3, 3, 3, 3, 3, 3, 3, 3};  tbl[0].e3 = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[0].esign = 8'hFE;
    tbl[1].mag = '{10, 2, 10, 10, 10, 10, 10, 10};  tbl[1].sign = 8'h00;
    tbl[1].e0  = '{2, 10, 2, 2, 2, 2, 2, 2};  tbl[1].e3 = '{0, 7, 0, 0, 0, 0, 0, 0};
    tbl[1].esign = 8'h00;
    tbl[2].mag = '{0, 0, 0, 0, 0, 0, 0, 0};  tbl[2].sign = 8'hFF;
    tbl[2].e0  = '{0, 0, 0, 0, 0, 0, 0, 0};  tbl[2].e3 = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].esign = 8'hFF;
    tbl[3].mag = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    tbl[3].sign = 8'h80;
    tbl[3].e0  = '{65535, 65535, 65535, 65535, 65535, 65535, 65535, 65535};
    tbl[3].e3  = '{65532, 65532, 65532, 65532, 65532, 65532, 65532, 65532};
    tbl[3].esign = 8'h7F;
    tbl[4].mag = '{7, 6, 5, 4, 3, 2, 1, 100};  tbl[4].sign = 8'h03;
    tbl[4].e0  = '{1, 1, 1, 1, 1, 1, 2, 1};  tbl[4].e3 = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4].esign = 8'h03;

    rst = 1'b1; mag_d = '0; sign_d = '0; valid_d = 1'b0; last_d = 1'b0; ready_d = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out0.valid, 0);
    chk("rst_ready", in0.ready, 0);
    chk("rst_outs", cur_out(), 0);
    chk("rst_state", dbg0, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in0.ready, 1);

    // single-beat table
    for (int i = 0; i < 5; i++) begin
      row_sign[0] = tbl[i].sign;
      for (int k = 0; k < 8; k++) begin
        row_mag[0][k] = tbl[i].mag[k];
        v0[k*W +: W] = tbl[i].e0[k];
        v3[k*W +: W] = tbl[i].e3[k];
      end
      exp_q.push_back({1'b1, tbl[i].esign, tbl[i].esign, v0, v3});
      send_row(1, 1'b1);
      collect(1, 0);
      post_check();
    end

    // three beats, unique min 2 at index 14, next smallest 4
    for (int b = 0; b < 3; b++) begin
      row_sign[b] = 8'h00;
      for (int k = 0; k < 8; k++) row_mag[b][k] = 20;
    end
    row_mag[1][6] = 2;
    row_mag[2][3] = 4;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++) begin
        v0[k*W +: W] = (b == 1 && k == 6) ? W'(4) : W'(2);
        v3[k*W +: W] = (b == 1 && k == 6) ? W'(1) : W'(0);
      end
      exp_q.push_back({(b == 2), 8'h00, 8'h00, v0, v3});
    end
    send_row(3, 1'b1);
    collect(3, 0);
    post_check();

    // forced row end after eight beats without i_last
    rand_row(8);
    push_model(8);
    send_row(8, 1'b0);
    collect(8, 2);
    post_check();

    // downstream stalls 1,0,0,1
    rand_row(4);
    push_model(4);
    send_row(4, 1'b1);
    collect(4, 1);
    post_check();

    // reset in EMIT after the first output beat
    rand_row(3);
    push_model(3);
    send_row(3, 1'b1);
    collect(1, 0);
    @(negedge clk);
    ready_d = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out0.valid, 0);
    chk("mid_rst_ready", in0.ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("after_rst_valid", out0.valid, 0);
    chk("after_rst_ready", in0.ready, 1);
    chk("after_rst_state", dbg0, 0);
    exp_q.delete();
    rand_row(2);
    push_model(2);
    send_row(2, 1'b1);
    collect(2, 0);
    post_check();

    // random rows
    for (int r = 0; r < 30; r++) begin
      n = $urandom_range(1, 8);
      use_last = (n < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      rand_row(n);
      push_model(n);
      send_row(n, use_last);
      collect(n, mode);
      post_check();
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ldpc_cn_minsum.md
LDPC_CN_MINSUM -- requirements
Module: ldpc_cn_minsum

Interface
REQ-001 Parameter WIDTH, default 16, magnitude width per lane (unsigned).
REQ-002 Parameter MAX_BEATS, default 8, maximum input beats per check row (8 lanes/beat).
REQ-003 Parameter OFFSET, default 0, offset-min-sum correction subtracted from output magnitudes.
REQ-004 i_clock  input  1  clock; all state on rising edge.
REQ-005 i_reset  input  1  reset, synchronous, active-high.
REQ-006 i_mag  input  8*WIDTH  lane magnitudes, lane k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-007 i_sign  input  8  lane sign bits, 1 = negative.
REQ-008 i_valid  input  1  input beat valid.
REQ-009 i_last  input  1  final beat of the row, qualified by i_valid.
REQ-010 o_ready  output  1  block accepts an input beat.
REQ-011 o_mag  output  8*WIDTH  extrinsic magnitudes, same lane packing as i_mag.
REQ-012 o_sign  output  8  extrinsic signs.
REQ-013 o_valid  output  1  output beat valid.
REQ-014 o_last  output  1  final output beat of the row.
REQ-015 i_ready  input  1  downstream accepts output beat.

Function
REQ-016 States IDLE, ACCUM, EMIT; input beat accepted when i_valid && o_ready; output beat transferred when o_valid && i_ready.
REQ-017 o_ready = 1 in IDLE and ACCUM, 0 in EMIT; o_valid = 1 only in EMIT.
REQ-018 IDLE -> ACCUM on first accepted beat that is not last; IDLE -> EMIT on accepted beat with i_last.
REQ-019 ACCUM -> EMIT on accepted beat with i_last, or when accepted beat count reaches MAX_BEATS (forced last).
REQ-020 EMIT -> IDLE on transfer of output beat with o_last; o_ready high the following cycle.
REQ-021 All magnitude comparisons unsigned; per row track min1, min2 (smallest and second smallest), min1 index (beat*8+lane), and sign product (XOR of all accepted signs).
REQ-022 Ties: min1 keeps lowest index; equal magnitude at another index sets min2 = min1 value.
REQ-023 Row of N edges with one distinct minimum: min2 = smallest among others; single-beat row uses only that beat's 8 lanes.
REQ-024 Running trackers initialise from the first beat of each row; no carry-over between rows.
REQ-025 Per-beat sign vectors stored in a MAX_BEATS x 8 register array indexed by beat number.
REQ-026 EMIT produces exactly as many beats as were accepted, in input order, one per cycle while i_ready high.
REQ-027 Lane magnitude = max((index == min1 index ? min2 : min1) - OFFSET, 0), saturating at 0, WIDTH bits.
REQ-028 Lane sign = sign product XOR that lane's stored input sign.
REQ-029 First output beat valid the cycle after the last input beat is accepted.
REQ-030 o_mag, o_sign, o_last held stable while o_valid && !i_ready.
REQ-031 o_last = 1 only on the final output beat.

Reset
REQ-032 During i_reset: state IDLE, beat counters 0, trackers 0, sign array 0.
REQ-033 Output reset values: o_valid 0, o_last 0, o_mag 0, o_sign 0, o_ready 0 during reset cycle, 1 on first cycle after.
REQ-034 Reset mid-ACCUM or mid-EMIT discards the row; no partial output after reset.

Verification
REQ-035 Single beat, i_last=1, mags {5,3,9,7,3,8,6,4}, signs 0x01, OFFSET 0 -> one output beat: lane1=3 (tie min2), others=3; signs = 0x01 XOR 1 per lane = 0xFE; o_last=1.
REQ-036 Three beats, unique min 2 at beat1 lane6, next smallest 4 -> lane 14 outputs 4, all other 23 lanes 2; outputs appear cycle after third acceptance.
REQ-037 OFFSET=3, min1=2, min2=10 -> non-min lanes 0 (saturated), min lane 7.
REQ-038 MAX_BEATS beats with i_last never asserted -> forced EMIT after beat MAX_BEATS, o_ready 0 thereafter until o_last transferred.
REQ-039 i_ready toggled 1,0,0,1 during EMIT -> outputs held stable, no beat lost or duplicated, o_last on final.
REQ-040 Assert i_reset in EMIT after first output beat -> o_valid 0 next cycle, following row starts clean with correct results.
